// File: rtl/sub_test_sequencer_if.sv
// sub_test_sequencer_if: run-control and sub status/reset signals for the test sequencer
interface sub_test_sequencer_if #(
  parameter int CNT_W = 16
);
  logic start;
  logic abort;
  logic dut_done;
  logic dut_error;
  logic dut_reset_l;
  logic busy;
  logic pass;
  logic fail;
  logic timeout;
  logic [CNT_W-1:0] run_cycles;
  modport master (
    output start, abort, dut_done, dut_error,
    input  dut_reset_l, busy, pass, fail, timeout, run_cycles
  );
  modport slave (
    input  start, abort, dut_done, dut_error,
    output dut_reset_l, busy, pass, fail, timeout, run_cycles
  );
endinterface

// File: rtl/sub_test_sequencer.sv
// sub_test_sequencer: sequences sub reset, runs it under a watchdog and latches a sticky verdict
module sub_test_sequencer #(
  parameter int RST0_CYC = 1,
  parameter int REL_CYC  = 1,
  parameter int RST1_CYC = 1,
  parameter int TIMEOUT  = 1000,
  parameter int CNT_W    = 16
) (
  input logic clk,
  input logic reset,
  sub_test_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RST0, REL, RST1, RUN, PASS, FAIL, TOUT} state_t;
  localparam logic [CNT_W-1:0] R0_END = CNT_W'(RST0_CYC - 1);
  localparam logic [CNT_W-1:0] RL_END = CNT_W'(REL_CYC - 1);
  localparam logic [CNT_W-1:0] R1_END = CNT_W'(RST1_CYC - 1);
  localparam logic [CNT_W-1:0] TO_END = CNT_W'(TIMEOUT - 1);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic run_exit;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, PASS, FAIL, TOUT: nxt = bus.start ? RST0 : state;
      RST0: nxt = (cnt == R0_END) ? REL : RST0;
      REL:  nxt = (cnt == RL_END) ? RST1 : REL;
      RST1: nxt = (cnt == R1_END) ? RUN : RST1;
      RUN:  nxt = bus.dut_error ? FAIL : bus.dut_done ? PASS : (cnt == TO_END) ? TOUT : RUN;
      default: nxt = IDLE;
    endcase
    nxt = bus.abort ? IDLE : nxt;
  end
  // an abort leaves RUN without a verdict, so run_cycles only latches on a real exit
  assign run_exit = (state == RUN) && (nxt inside {PASS, FAIL, TOUT});
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.dut_reset_l <= 1'b0;
      bus.busy        <= 1'b0;
      bus.pass        <= 1'b0;
      bus.fail        <= 1'b0;
      bus.timeout     <= 1'b0;
      bus.run_cycles  <= '0;
    end else begin
      state           <= nxt;
      cnt             <= (nxt != state) ? '0 : cnt + 1'b1;
      bus.dut_reset_l <= (nxt == REL) || (nxt == RUN);
      bus.busy        <= nxt inside {RST0, REL, RST1, RUN};
      bus.pass        <= nxt == PASS;
      bus.fail        <= nxt == FAIL;
      bus.timeout     <= nxt == TOUT;
      bus.run_cycles  <= run_exit ? cnt + 1'b1 : bus.run_cycles;
    end
  end
endmodule
